// File: rtl/laneswitch_nway.sv
// N-lane arbiter-switch sharing one dual-port memory between lanes.
// Ownership moves via req/ack after in-flight reads have drained.
module laneswitch_nway #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int NUM_LANES   = 4,
  parameter int LANE_BITS   = 2,
  parameter int MEM_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sel_req,
  input  logic [LANE_BITS-1:0]            sel_lane,
  output logic                            sel_ack,
  output logic [LANE_BITS-1:0]            owner,
  output logic [NUM_LANES-1:0]            grant,
  output logic                            busy,
  output logic                            active,
  output logic                            fault,
  input  logic                            fault_clr,
  output logic [ADDR_WIDTH-1:0]           mem_address0,
  output logic [ADDR_WIDTH-1:0]           mem_address1,
  output logic [DATA_WIDTH-1:0]           mem_d0,
  output logic [DATA_WIDTH-1:0]           mem_d1,
  input  logic [DATA_WIDTH-1:0]           mem_q0,
  input  logic [DATA_WIDTH-1:0]           mem_q1,
  output logic                            mem_ce0,
  output logic                            mem_ce1,
  output logic                            mem_we0,
  output logic                            mem_we1,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] lane_address0,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] lane_address1,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_d0,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_d1,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lane_q0,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lane_q1,
  input  logic [NUM_LANES-1:0]            lane_ce0,
  input  logic [NUM_LANES-1:0]            lane_ce1,
  input  logic [NUM_LANES-1:0]            lane_we0,
  input  logic [NUM_LANES-1:0]            lane_we1
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int L  = MEM_LATENCY;

  logic [1:0]           state_q, state_d;
  logic [LANE_BITS-1:0] owner_q, owner_d;
  logic [LANE_BITS-1:0] target_q, target_d;
  logic                 fault_q, fault_d;

  logic [1:0][AW-1:0] addr_q, addr_d;
  logic [1:0][DW-1:0] wd_q, wd_d;
  logic [1:0]         ce_q, ce_d;
  logic [1:0]         we_q, we_d;

  logic [1:0][L-1:0]                pv_q, pv_d;
  logic [1:0][L-1:0][LANE_BITS-1:0] pl_q, pl_d;

  logic [1:0][NUM_LANES*AW-1:0] l_addr;
  logic [1:0][NUM_LANES*DW-1:0] l_d;
  logic [1:0][NUM_LANES*DW-1:0] l_q;
  logic [1:0][NUM_LANES-1:0]    l_ce;
  logic [1:0][NUM_LANES-1:0]    l_we;
  logic [1:0][DW-1:0]           m_q;

  logic gate;
  logic viol;
  logic fault_set;

  assign l_addr = {lane_address1, lane_address0};
  assign l_d    = {lane_d1, lane_d0};
  assign l_ce   = {lane_ce1, lane_ce0};
  assign l_we   = {lane_we1, lane_we0};
  assign m_q    = {mem_q1, mem_q0};

  assign gate = (state_q == IDLE) || (state_q == DONE);

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      grant[i] = gate && (owner_q == LANE_BITS'(i));
    end
  end

  // Any lane driving ce without its grant bit is a protocol violation.
  assign viol = |((l_ce[0] | l_ce[1]) & ~grant);

  always_comb begin
    addr_d = '0;
    wd_d   = '0;
    ce_d   = '0;
    we_d   = '0;
    pv_d   = '0;
    pl_d   = '0;
    l_q    = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (owner_q == LANE_BITS'(i)) begin
          addr_d[p] = l_addr[p][i*AW +: AW];
          wd_d[p]   = l_d[p][i*DW +: DW];
          ce_d[p]   = l_ce[p][i] & grant[i];
          we_d[p]   = l_we[p][i] & l_ce[p][i] & grant[i];
        end
        if (pv_q[p][L-1] && pl_q[p][L-1] == LANE_BITS'(i)) begin
          l_q[p][i*DW +: DW] = m_q[p];
        end
      end
      pv_d[p][0] = ce_q[p] & ~we_q[p];
      pl_d[p][0] = owner_q;
      for (int s = 1; s < L; s++) begin
        pv_d[p][s] = pv_q[p][s-1];
        pl_d[p][s] = pl_q[p][s-1];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    target_d  = target_q;
    fault_set = viol;
    unique case (state_q)
      IDLE: begin
        if (sel_req) begin
          if (sel_lane == owner_q) begin
            state_d = DONE;
          end else if (int'(sel_lane) >= NUM_LANES) begin
            state_d   = DONE;
            fault_set = 1'b1;
          end else begin
            target_d = sel_lane;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!(|ce_q) && !(|pv_q)) state_d = SWITCH;
      end
      SWITCH: begin
        owner_d = target_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fault_set)      fault_d = 1'b1;
    else if (fault_clr) fault_d = 1'b0;
    else                fault_d = fault_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      target_q <= '0;
      fault_q  <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      ce_q     <= '0;
      we_q     <= '0;
      pv_q     <= '0;
      pl_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      target_q <= target_d;
      fault_q  <= fault_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      pv_q     <= pv_d;
      pl_q     <= pl_d;
    end
  end

  assign sel_ack      = (state_q == DONE);
  assign owner        = owner_q;
  assign fault        = fault_q;
  assign active       = |ce_q;
  assign busy         = (state_q != IDLE) | (|pv_q) | (|ce_q);
  assign mem_address0 = addr_q[0];
  assign mem_address1 = addr_q[1];
  assign mem_d0       = wd_q[0];
  assign mem_d1       = wd_q[1];
  assign mem_ce0      = ce_q[0];
  assign mem_ce1      = ce_q[1];
  assign mem_we0      = we_q[0];
  assign mem_we1      = we_q[1];
  assign lane_q0      = l_q[0];
  assign lane_q1      = l_q[1];

endmodule

// File: tb/tb_laneswitch_nway.sv
// Directed bench for laneswitch_nway with a behavioural 2-port memory.
// Uses MEM_LATENCY=3 and a 3-bit lane index so invalid lanes are testable.
module tb_laneswitch_nway;

  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int N   = 4;
  localparam int LB  = 3;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel_req;
  logic [LB-1:0] sel_lane;
  logic          sel_ack;
  logic [LB-1:0] owner;
  logic [N-1:0]  grant;
  logic          busy, active, fault, fault_clr;
  logic [AW-1:0] mem_address0, mem_address1;
  logic [DW-1:0] mem_d0, mem_d1, mem_q0, mem_q1;
  logic          mem_ce0, mem_ce1, mem_we0, mem_we1;
  logic [N*AW-1:0] lane_address0, lane_address1;
  logic [N*DW-1:0] lane_d0, lane_d1, lane_q0, lane_q1;
  logic [N-1:0]  lane_ce0, lane_ce1, lane_we0, lane_we1;

  int n_chk = 0;
  int n_pass = 0;

  laneswitch_nway #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LANES(N),
    .LANE_BITS(LB), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .sel_req(sel_req), .sel_lane(sel_lane), .sel_ack(sel_ack),
    .owner(owner), .grant(grant), .busy(busy), .active(active),
    .fault(fault), .fault_clr(fault_clr),
    .mem_address0(mem_address0), .mem_address1(mem_address1),
    .mem_d0(mem_d0), .mem_d1(mem_d1),
    .mem_q0(mem_q0), .mem_q1(mem_q1),
    .mem_ce0(mem_ce0), .mem_ce1(mem_ce1),
    .mem_we0(mem_we0), .mem_we1(mem_we1),
    .lane_address0(lane_address0), .lane_address1(lane_address1),
    .lane_d0(lane_d0), .lane_d1(lane_d1),
    .lane_q0(lane_q0), .lane_q1(lane_q1),
    .lane_ce0(lane_ce0), .lane_ce1(lane_ce1),
    .lane_we0(lane_we0), .lane_we1(lane_we1)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] qp0 [LAT];
  logic [DW-1:0] qp1 [LAT];

  initial for (int k = 0; k < 64; k++) mem[k] = '0;
  initial for (int k = 0; k < LAT; k++) begin
    qp0[k] = '0;
    qp1[k] = '0;
  end

  always @(posedge clk) begin
    if (mem_ce0 && mem_we0) mem[mem_address0] <= mem_d0;
    if (mem_ce1 && mem_we1) mem[mem_address1] <= mem_d1;
    qp0[0] <= mem_ce0 ? mem[mem_address0] : '0;
    qp1[0] <= mem_ce1 ? mem[mem_address1] : '0;
    for (int k = 1; k < LAT; k++) begin
      qp0[k] <= qp0[k-1];
      qp1[k] <= qp1[k-1];
    end
  end

  assign mem_q0 = qp0[LAT-1];
  assign mem_q1 = qp1[LAT-1];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] q0_of(input int i);
    return lane_q0[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] q1_of(input int i);
    return lane_q1[i*DW +: DW];
  endfunction

  task automatic clear_lanes();
    lane_address0 = '0;
    lane_address1 = '0;
    lane_d0 = '0;
    lane_d1 = '0;
    lane_ce0 = '0;
    lane_ce1 = '0;
    lane_we0 = '0;
    lane_we1 = '0;
  endtask

  task automatic do_switch(input logic [LB-1:0] ln);
    logic got_ack;
    got_ack = 1'b0;
    sel_req = 1'b1;
    sel_lane = ln;
    for (int c = 0; c < 40 && !got_ack; c++) begin
      step();
      got_ack = sel_ack;
    end
    check("sw_ack", {63'd0, got_ack}, 64'd1);
    sel_req = 1'b0;
    step();
  endtask

  initial begin
    logic [DW-1:0] d0;
    logic leak;
    int ack_cyc;

    reset = 1'b1;
    sel_req = 1'b0;
    sel_lane = '0;
    fault_clr = 1'b0;
    clear_lanes();
    step();
    step();
    reset = 1'b0;
    step();

    check("rst_owner", 64'(owner), 64'd0);
    check("rst_grant", 64'(grant), 64'b0001);
    check("rst_ack", 64'(sel_ack), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem", {mem_address0, mem_ce0, mem_we0, mem_ce1}, 64'd0);
    check("rst_lq", 64'(lane_q0[63:0] | lane_q1[63:0]), 64'd0);

    // Lane 0 writes A5 to address 3 on port 0 then reads it on port 1.
    lane_ce0[0] = 1'b1;
    lane_we0[0] = 1'b1;
    lane_address0[0 +: AW] = 6'd3;
    lane_d0[0 +: DW] = 32'hA5;
    step();
    check("wr_mem_ce0", {mem_ce0, mem_we0, mem_address0}, {2'b11, 6'd3});
    check("wr_mem_d0", 64'(mem_d0), 64'hA5);
    clear_lanes();
    lane_ce1[0] = 1'b1;
    lane_address1[0 +: AW] = 6'd3;
    step();
    check("rd_mem_ce1", {active, mem_ce1, mem_we1}, 3'b110);
    clear_lanes();
    step();
    step();
    check("rd_early", 64'(q1_of(0)), 64'd0);
    step();
    check("rd_lane0", 64'(q1_of(0)), 64'hA5);
    check("rd_others", {q1_of(1), q1_of(2)} | 64'(q1_of(3)), 64'd0);
    check("rd_fault", 64'(fault), 64'd0);
    step();
    check("rd_after", 64'(q1_of(0)), 64'd0);

    // Idle switch 0 -> 2: DRAIN, SWITCH, DONE in cycles 1..3.
    sel_req = 1'b1;
    sel_lane = 3'd2;
    step();
    check("sw_c1", {sel_ack, busy, grant}, {2'b01, 4'b0000});
    step();
    check("sw_c2", {sel_ack, busy, grant}, {2'b01, 4'b0000});
    step();
    check("sw_c3", {sel_ack, busy, owner, grant}, {2'b11, 3'd2, 4'b0100});
    sel_req = 1'b0;
    step();
    check("sw_c4", {sel_ack, busy, owner}, {2'b00, 3'd2});

    do_switch(3'd0);
    check("back_owner0", 64'(owner), 64'd0);

    // Lane 0 read coincident with a request for lane 1.
    sel_req = 1'b1;
    sel_lane = 3'd1;
    lane_ce0[0] = 1'b1;
    lane_address0[0 +: AW] = 6'd3;
    ack_cyc = 0;
    d0 = '0;
    leak = 1'b0;
    for (int c = 1; c <= 10 && ack_cyc == 0; c++) begin
      step();
      clear_lanes();
      if (c == 1 + LAT) d0 = q0_of(0);
      if (q0_of(1) != '0 || q1_of(1) != '0) leak = 1'b1;
      if (sel_ack) ack_cyc = c;
    end
    sel_req = 1'b0;
    check("drain_data", 64'(d0), 64'hA5);
    check("drain_leak", 64'(leak), 64'd0);
    check("drain_ack_cyc", 64'(ack_cyc), 64'd7);
    check("drain_owner", 64'(owner), 64'd1);
    check("drain_fault", 64'(fault), 64'd0);
    step();

    do_switch(3'd0);

    // Lane 3 issues without a grant.
    lane_ce0[3] = 1'b1;
    lane_we0[3] = 1'b1;
    lane_address0[3*AW +: AW] = 6'd7;
    lane_d0[3*DW +: DW] = 32'hDEAD;
    step();
    clear_lanes();
    check("viol_ce0", {mem_ce0, mem_we0}, 2'b00);
    check("viol_fault", 64'(fault), 64'd1);
    step();
    check("viol_sticky", 64'(fault), 64'd1);
    check("viol_mem", 64'(mem[7]), 64'd0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("clr_fault", 64'(fault), 64'd0);
    fault_clr = 1'b1;
    lane_ce1[2] = 1'b1;
    step();
    clear_lanes();
    fault_clr = 1'b0;
    check("clr_vs_set", {fault, mem_ce1}, 2'b10);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("clr_fault2", 64'(fault), 64'd0);

    // Invalid lane, then same-lane request.
    sel_req = 1'b1;
    sel_lane = 3'd5;
    step();
    sel_req = 1'b0;
    check("inv_ack", {sel_ack, owner, fault}, {1'b1, 3'd0, 1'b1});
    step();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    sel_req = 1'b1;
    sel_lane = 3'd0;
    step();
    sel_req = 1'b0;
    check("same_ack", {sel_ack, owner, fault}, {1'b1, 3'd0, 1'b0});
    step();

    // Reset during DRAIN with a read in flight.
    do_switch(3'd2);
    sel_req = 1'b1;
    sel_lane = 3'd3;
    lane_ce0[2] = 1'b1;
    lane_address0[2*AW +: AW] = 6'd3;
    step();
    clear_lanes();
    sel_req = 1'b0;
    check("drn_busy", {busy, mem_ce0, sel_ack}, 3'b110);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstd_state", {owner, grant, sel_ack, busy}, {3'd0, 4'b0001, 2'b00});
    leak = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      step();
      if (lane_q0 != '0 || busy) leak = 1'b1;
    end
    check("rstd_pipe", 64'(leak), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/laneswitch_nway.md
# laneswitch_nway

Parametrised N-lane arbiter-switch that time-multiplexes one dual-port on-chip memory buffer between NUM_LANES producer/consumer lanes. It sits between the lane-side memory interfaces of the tasks sharing a buffer and the physical 2-port memory. A single lane owns the memory at a time. Ownership changes only through a req/ack handshake that drains in-flight reads first. Read data is returned only to the lane that issued the read, and non-owning lanes see zero, never high-Z.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 6, memory address width
- NUM_LANES, 4, number of lanes (2..16)
- LANE_BITS, 2, lane index width (>= clog2(NUM_LANES))
- MEM_LATENCY, 1, memory read latency in cycles from registered ce to valid q (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock, reset is synchronous and active-high
- sel_req  in  1  ownership change request; held with sel_lane until sel_ack
- sel_lane  in  LANE_BITS  requested new owner
- sel_ack  out  1  one-cycle acknowledge
- owner  out  LANE_BITS  current owner index
- grant  out  NUM_LANES  one-hot grant; lanes issue only while their bit is set
- busy  out  1  switch in progress or reads in flight
- active  out  1  mem_ce0 | mem_ce1
- fault  out  1  sticky protocol-violation flag
- fault_clr  in  1  clears fault
- mem_address0/1  out  ADDR_WIDTH  registered memory address per port
- mem_d0/1  out  DATA_WIDTH  registered write data
- mem_q0/1  in  DATA_WIDTH  memory read data
- mem_ce0/1, mem_we0/1  out  1  registered enables
- lane_address0/1  in  NUM_LANES*ADDR_WIDTH  lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- lane_d0/1  in  NUM_LANES*DATA_WIDTH  lane write data, same packing
- lane_q0/1  out  NUM_LANES*DATA_WIDTH  per-lane read data
- lane_ce0/1, lane_we0/1  in  NUM_LANES  per-lane enables

## Operation
- States: IDLE, DRAIN, SWITCH, DONE.
  - grant = onehot(owner) in IDLE and DONE.
  - grant = 0 in DRAIN and SWITCH.
- Request path, per port: every cycle, mem_address/d are registered from lane[owner]. mem_ce/mem_we are registered as lane[owner].ce & grant[owner], and we is additionally ANDed with ce.
- Read tracking, per port: a shift pipeline of depth MEM_LATENCY holds {valid, lane}. It is loaded with {mem_ce & ~mem_we, owner-at-issue}.
- Read return: lane_q of lane i = mem_q when the pipeline output is valid and its lane equals i; otherwise 0.
- IDLE, on sel_req=1:
  - sel_lane == owner → DONE.
  - sel_lane >= NUM_LANES → DONE, set fault, owner unchanged.
  - otherwise latch target → DRAIN.
- DRAIN: wait until mem_ce0=mem_ce1=0 and both pipelines are empty → SWITCH.
- SWITCH: owner <= target → DONE.
- DONE: sel_ack=1 → IDLE. The requester drops sel_req at the edge where it sees ack. sel_req is sampled only in IDLE.
- Fault sets when any lane asserts ce0/ce1 while its grant bit is 0; that access is dropped. Fault also sets on an invalid sel_lane.
- fault_clr clears fault; a set condition in the same cycle wins.
- busy = (state != IDLE) | any pipeline valid | mem_ce0 | mem_ce1.

## Timing
- Reset values: state IDLE, owner 0, grant = 1, sel_ack 0, fault 0, busy 0, all mem_* outputs 0, pipelines cleared, lane_q all 0.
- Reset asserted mid-DRAIN or mid-SWITCH aborts the change; owner returns to 0.
- Request latency: lane ce in cycle t → mem_ce in t+1 → q at lane in t+1+MEM_LATENCY.
- Switch latency with no traffic, sel_req in cycle 0: DRAIN 1, SWITCH 2, DONE 3 (ack; new owner and grant visible). New owner may issue from cycle 3.
- With traffic, DRAIN lasts until the last read returns: at most 1+MEM_LATENCY cycles after the last accepted request.
- Same-lane or invalid request: ack in cycle 1.
- Writes need no drain beyond the registered stage.
- Lane-to-port mapping: port 0 and port 1 are independent. Simultaneous read and write on different ports by the owner is allowed. Same-address conflicts are the memory's behaviour.

## Test plan
- Reset, then lane0 writes 0xA5 to addr 3 on port0 and reads it on port1 → lane0_q1 = 0xA5 at t+1+MEM_LATENCY; lanes 1..3 q = 0; fault 0.
- No traffic, sel_req with sel_lane=2 in cycle 0 → sel_ack in cycle 3, owner=2, grant=4'b0100, busy high in cycles 1-3.
- MEM_LATENCY=3; lane0 reads in the same cycle sel_req(lane1) arrives → read data still delivered to lane0; sel_ack is delayed until the pipeline empties; lane1 never sees the data.
- Lane3 asserts ce0 while owner=0 → memory untouched (mem_ce0 stays 0), fault=1 sticky. fault_clr for one cycle → fault=0. fault_clr coincident with a new violation → fault stays 1.
- sel_lane=5 with NUM_LANES=4 → ack in cycle 1, owner unchanged, fault=1. sel_lane=owner → ack in cycle 1, no fault.
- Reset asserted in the DRAIN cycle → next cycle owner=0, grant=1, sel_ack=0, pipelines empty.
